// File: rtl/simon_pkg.sv
// Shared Simon 32/64 constants, FSM state type and word helpers.
package simon_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] C_CONST = 16'hFFFC;
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DECRYPT,
    DONE
  } state_t;

  function automatic logic [WORD_W-1:0] rol(
    input logic [WORD_W-1:0] v,
    input logic [3:0]        n
  );
    return (v << n) | (v >> (5'd16 - {1'b0, n}));
  endfunction

  function automatic logic [WORD_W-1:0] ror(
    input logic [WORD_W-1:0] v,
    input logic [3:0]        n
  );
    return (v >> n) | (v << (5'd16 - {1'b0, n}));
  endfunction

  function automatic logic [WORD_W-1:0] simon_f(
    input logic [WORD_W-1:0] v
  );
    return (rol(v, 4'd1) & rol(v, 4'd8)) ^ rol(v, 4'd2);
  endfunction

  // z_j counts from the leftmost bit of the sequence.
  function automatic logic z_bit(input logic [4:0] j);
    return Z0[6'd61 - {1'b0, j}];
  endfunction

endpackage

// File: rtl/simon_key_step.sv
// One Simon 32/64 key-schedule step; dir=0 yields k[i+4], dir=1 yields k[i].
module simon_key_step
  import simon_pkg::*;
(
  input  logic [63:0]       win,
  input  logic              z,
  input  logic              dir,
  output logic [WORD_W-1:0] key
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] a, b, d, t;

  assign w0 = win[15:0];
  assign w1 = win[31:16];
  assign w2 = win[47:32];
  assign w3 = win[63:48];

  // Inverse step reuses the forward equation with the window shifted by one.
  assign a = dir ? w3 : w0;
  assign b = dir ? w2 : w3;
  assign d = dir ? w0 : w1;

  assign t   = ror(b, 4'd3) ^ d;
  assign key = a ^ C_CONST ^ {15'b0, z} ^ t ^ ror(t, 4'd1);

endmodule

// File: rtl/simon_dec_iter.sv
// Iterative Simon 32/64 decryptor: forward key expansion, then reverse rounds.
// Optional SIMON_DEC_KEY_CACHE_EN reuses the expanded tail for a repeated key.
module simon_dec_iter
  import simon_pkg::*;
#(
  parameter int ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_ciphertext,
  input  logic [63:0] in_keytext,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_plaintext,
  output logic        busy
);

  localparam logic [4:0] LAST_EXP = 5'(ROUNDS - 5);
  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] x, y, x_nxt, y_nxt;
  logic [63:0]       win, win_nxt;
  logic [4:0]        cnt, cnt_nxt;
  logic [31:0]       pt_nxt;
  logic              ov_nxt;
  logic              dir;
  logic [4:0]        z_idx;
  logic [WORD_W-1:0] key_new;
  logic [WORD_W-1:0] rnd_y;
  logic              hit;

`ifdef SIMON_DEC_KEY_CACHE_EN
  logic        cache_valid;
  logic [63:0] cache_key;
  logic [63:0] cache_win;
  logic [63:0] key_reg;

  assign hit = cache_valid && (cache_key == in_keytext);
`else
  assign hit = 1'b0;
`endif

  assign dir   = (state == DECRYPT);
  assign z_idx = dir ? (cnt - 5'd4) : cnt;
  assign rnd_y = x ^ simon_f(y) ^ win[63:48];

  simon_key_step u_key_step (
    .win (win),
    .z   (z_bit(z_idx)),
    .dir (dir),
    .key (key_new)
  );

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    win_nxt   = win;
    cnt_nxt   = cnt;
    pt_nxt    = out_plaintext;
    ov_nxt    = out_valid;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          x_nxt     = in_ciphertext[31:16];
          y_nxt     = in_ciphertext[15:0];
          win_nxt   = in_keytext;
          cnt_nxt   = 5'd0;
          state_nxt = EXPAND;
`ifdef SIMON_DEC_KEY_CACHE_EN
          if (hit) begin
            win_nxt   = cache_win;
            cnt_nxt   = LAST_RND;
            state_nxt = DECRYPT;
          end
`endif
        end
      end
      EXPAND: begin
        win_nxt = {key_new, win[63:16]};
        cnt_nxt = cnt + 5'd1;
        if (cnt == LAST_EXP) begin
          cnt_nxt   = LAST_RND;
          state_nxt = DECRYPT;
        end
      end
      DECRYPT: begin
        x_nxt   = y;
        y_nxt   = rnd_y;
        win_nxt = {win[47:0], key_new};
        cnt_nxt = cnt - 5'd1;
        if (cnt == 5'd0) begin
          pt_nxt    = {y, rnd_y};
          ov_nxt    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      win           <= '0;
      cnt           <= '0;
      out_plaintext <= '0;
      out_valid     <= 1'b0;
    end else begin
      state         <= state_nxt;
      x             <= x_nxt;
      y             <= y_nxt;
      win           <= win_nxt;
      cnt           <= cnt_nxt;
      out_plaintext <= pt_nxt;
      out_valid     <= ov_nxt;
    end
  end

`ifdef SIMON_DEC_KEY_CACHE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_key   <= '0;
      cache_win   <= '0;
      key_reg     <= '0;
    end else begin
      if (state == IDLE && in_valid && !hit)
        key_reg <= in_keytext;
      if (state == EXPAND && cnt == LAST_EXP) begin
        cache_valid <= 1'b1;
        cache_key   <= key_reg;
        cache_win   <= {key_new, win[63:16]};
      end
    end
  end
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state == EXPAND) || (state == DECRYPT);

endmodule

// File: tb/tb_simon_dec_iter.sv
// Directed bench for simon_dec_iter: known answer, backpressure,
// encrypt-model round trips, held in_valid and mid-run reset.
module tb_simon_dec_iter;

  localparam int R = 32;
  localparam logic [61:0] ZSEQ =
    62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [63:0] KAT_KEY = 64'h1918111009080100;
  localparam logic [31:0] KAT_CT  = 32'hC69BE9BB;
  localparam logic [31:0] KAT_PT  = 32'h65656877;

`ifdef SIMON_DEC_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ciphertext;
  logic [63:0] in_keytext;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_plaintext;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  bit          mc_valid = 1'b0;
  logic [63:0] mc_key   = '0;

  simon_dec_iter #(.ROUNDS(R)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ciphertext (in_ciphertext),
    .in_keytext    (in_keytext),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_plaintext (out_plaintext),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rr(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  function automatic logic [15:0] rl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  // Reference encryptor used to produce ciphertexts for round trips.
  function automatic logic [31:0] enc(
    input logic [63:0] key,
    input logic [31:0] pt
  );
    logic [15:0] k [R];
    logic [15:0] x, y, t, tmp;
    logic [61:0] zs;
    zs = ZSEQ;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 0; i < R - 4; i++) begin
      t = rr(k[i+3], 3) ^ k[i+1];
      k[i+4] = 16'hFFFC ^ {15'b0, zs[61-i]} ^ k[i] ^ t ^ rr(t, 1);
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < R; i++) begin
      tmp = x;
      x = y ^ ((rl(x, 1) & rl(x, 8)) ^ rl(x, 2)) ^ k[i];
      y = tmp;
    end
    return {x, y};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic want_lat(input logic [63:0] key, output int w);
    bit h;
    h = CACHE && mc_valid && (mc_key == key);
    w = h ? (R + 1) : (2 * R - 3);
    mc_valid = CACHE;
    mc_key   = key;
  endtask

  task automatic wait_ready(input string tag);
    int g;
    g = 0;
    while (!in_ready && g < 200) begin
      tick;
      g++;
    end
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
  endtask

  task automatic block(
    input string       tag,
    input logic [63:0] key,
    input logic [31:0] ct,
    input logic [31:0] pt
  );
    int lat, w;
    wait_ready(tag);
    want_lat(key, w);
    in_valid      = 1'b1;
    in_keytext    = key;
    in_ciphertext = ct;
    lat = 0;
    do begin
      tick;
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 200);
    chk({tag, "_lat"}, 64'(lat), 64'(w));
    chk({tag, "_pt"}, 64'(out_plaintext), 64'(pt));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_ovclr"}, 64'(out_valid), 64'd0);
    chk({tag, "_irdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] rk;
    logic [31:0] rp;
    int lat, w;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_ciphertext = '0;
    in_keytext = '0;
    tick;
    tick;
    chk("rst_irdy", 64'(in_ready), 64'd1);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pt", 64'(out_plaintext), 64'd0);
    rst = 1'b0;
    tick;

    block("kat", KAT_KEY, KAT_CT, KAT_PT);
    block("kat_rep", KAT_KEY, KAT_CT, KAT_PT);

    for (int i = 0; i < 6; i++) begin
      rk = {$urandom, $urandom};
      rp = $urandom;
      block($sformatf("rt%0d", i), rk, enc(rk, rp), rp);
    end

    rk = 64'h0123456789ABCDEF;
    rp = 32'hDEADBEEF;
    block("rt_fix", rk, enc(rk, rp), rp);
    block("rt_fix_rep", rk, enc(rk, rp), rp);

    // in_valid held high across a whole block plus backpressure.
    wait_ready("b2b");
    want_lat(KAT_KEY, w);
    in_valid      = 1'b1;
    in_keytext    = KAT_KEY;
    in_ciphertext = KAT_CT;
    lat = 0;
    do begin
      tick;
      lat++;
      if (lat == 5) begin
        chk("b2b_irdy_busy", 64'(in_ready), 64'd0);
        chk("b2b_busy", 64'(busy), 64'd1);
      end
    end while (!out_valid && lat < 200);
    chk("b2b_lat", 64'(lat), 64'(w));
    chk("b2b_pt", 64'(out_plaintext), 64'(KAT_PT));
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_pt", 64'(out_plaintext), 64'(KAT_PT));
      chk("bp_ov", 64'(out_valid), 64'd1);
      chk("bp_irdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("bp_ovclr", 64'(out_valid), 64'd0);
    chk("bp_irdy1", 64'(in_ready), 64'd1);
    rk = 64'hA5A5_0F0F_3C3C_9696;
    rp = 32'h1234_5678;
    in_keytext    = rk;
    in_ciphertext = enc(rk, rp);
    want_lat(rk, w);
    lat = 0;
    do begin
      tick;
      lat++;
      if (lat == 1) begin
        chk("b2b2_busy", 64'(busy), 64'd1);
        in_valid = 1'b0;
      end
    end while (!out_valid && lat < 200);
    chk("b2b2_lat", 64'(lat), 64'(w));
    chk("b2b2_pt", 64'(out_plaintext), 64'(rp));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // Reset during DECRYPT discards the block and the cache.
    wait_ready("mrst");
    want_lat(KAT_KEY, w);
    in_valid      = 1'b1;
    in_keytext    = KAT_KEY;
    in_ciphertext = KAT_CT;
    tick;
    in_valid = 1'b0;
    for (int i = 1; i < 40; i++) tick;
    chk("mrst_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mc_valid = 1'b0;
    chk("mrst_ov", 64'(out_valid), 64'd0);
    chk("mrst_irdy", 64'(in_ready), 64'd1);
    chk("mrst_busy", 64'(busy), 64'd0);
    block("kat_post", KAT_KEY, KAT_CT, KAT_PT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
